// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: state encoding, coin codes
// and the code-to-value table (values in 0.5 yuan units).
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [1:0] COIN_HALF = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_FIVE = 2'b10;
  localparam logic [1:0] COIN_TEN  = 2'b11;

  // Indexed by denomination code.
  localparam logic [3:0][5:0] COIN_VALUE = {6'd20, 6'd10, 6'd2, 6'd1};

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    return COIN_VALUE[code];
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Picks the largest available denomination that still fits into the amount owed.
module coin_select
  import change_dispenser_pkg::*;
(
  input  logic [5:0] remaining,
  input  logic [3:0] hopper_empty,
  output logic [1:0] code,
  output logic       found
);

  // Ascending scan: the last hit is the largest fitting coin.
  always_comb begin
    code  = COIN_HALF;
    found = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (!hopper_empty[d] && (COIN_VALUE[d] <= remaining)) begin
        code  = 2'(d);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: hands out coins one at a time over a valid/ack
// link to the hopper, with a per-coin ack timeout and a sticky fault state.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] change_amt,
  input  logic [3:0] hopper_empty,
  input  logic       coin_out_ack,
  input  logic       clear,
  output logic       coin_out_valid,
  output logic [1:0] coin_out_val,
  output logic [5:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  rem_q, rem_d;
  logic [1:0]  val_q, val_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]  sel_code;
  logic        sel_found;

  coin_select u_coin_select (
    .remaining    (rem_q),
    .hopper_empty (hopper_empty),
    .code         (sel_code),
    .found        (sel_found)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = change_amt;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == 6'd0) begin
          state_d = ST_DONE;
        end else if (sel_found) begin
          val_d   = sel_code;
          cnt_d   = 16'd0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        // An ack on the final waiting cycle still wins over the timeout.
        if (coin_out_ack) begin
          if (coin_value(val_q) <= rem_q) rem_d = rem_q - coin_value(val_q);
          state_d = ST_SELECT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 6'd0;
      val_q   <= COIN_HALF;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign coin_out_valid = (state_q == ST_ISSUE);
  assign coin_out_val   = val_q;
  assign remaining      = rem_q;
  assign busy           = (state_q == ST_SELECT) || (state_q == ST_ISSUE) || (state_q == ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign fault          = (state_q == ST_FAULT);

endmodule
